// File: rtl/switch_bounce_gen_if.sv
// Command/status bundle for switch_bounce_gen: valid/ready command channel plus
// the emulated switch output and its busy/done status.
interface switch_bounce_gen_if #(
  parameter int BOUNCE_W = 8
);
  logic                i_valid;
  logic                o_ready;
  logic                i_level;
  logic [BOUNCE_W-1:0] i_bounce_len;
  logic                o_sig_bouncy;
  logic                o_busy;
  logic                o_done;

  modport master (
    output i_valid, i_level, i_bounce_len,
    input  o_ready, o_sig_bouncy, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_level, i_bounce_len,
    output o_ready, o_sig_bouncy, o_busy, o_done
  );
endinterface

// File: rtl/switch_bounce_gen.sv
// Mechanical switch emulator: LFSR-driven bounce burst, then a settled level.
// Optional macro SBG_FORCE_FIRST_EDGE_EN forces target on the first bounce edge.
//
// state  | meaning
// IDLE   | waiting for a command, ready high
// BOUNCE | counting down the burst, then settling on target
module switch_bounce_gen #(
  parameter int          BOUNCE_W  = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                clk,
  input  logic                rstn,
  switch_bounce_gen_if.slave  bus
);

  typedef enum logic {IDLE, BOUNCE} state_t;

  // All-zero is the LFSR lock-up state, so a zero seed is replaced.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] MASK = 16'hB400;

  state_t              state;
  state_t              state_nxt;
  logic [BOUNCE_W-1:0] cnt;
  logic                target;
  logic                sig;
  logic                done;
  logic [15:0]         lfsr;
  logic                ready;
  logic                busy;
  logic                accept;
  logic                cnt_zero;
`ifdef SBG_FORCE_FIRST_EDGE_EN
  logic                first;
`endif

  assign accept   = bus.i_valid && ready;
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = BOUNCE;
      BOUNCE:  if (cnt_zero) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    case (state)
      IDLE:    ready = 1'b1;
      BOUNCE:  busy  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt    <= '0;
      target <= 1'b0;
      sig    <= 1'b0;
      done   <= 1'b0;
      lfsr   <= SEED;
`ifdef SBG_FORCE_FIRST_EDGE_EN
      first  <= 1'b0;
`endif
    end else begin
      lfsr <= (lfsr >> 1) ^ (lfsr[0] ? MASK : 16'h0000);
      done <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          target <= bus.i_level;
          cnt    <= bus.i_bounce_len;
`ifdef SBG_FORCE_FIRST_EDGE_EN
          first  <= (bus.i_bounce_len != '0);
`endif
        end
      end else if (!cnt_zero) begin
        cnt <= cnt - BOUNCE_W'(1);
`ifdef SBG_FORCE_FIRST_EDGE_EN
        first <= 1'b0;
        if (first) sig <= target;
        else       sig <= sig ^ lfsr[0];
`else
        sig <= sig ^ lfsr[0];
`endif
      end else begin
        sig  <= target;
        done <= 1'b1;
      end
    end
  end

  assign bus.o_ready      = ready;
  assign bus.o_busy       = busy;
  assign bus.o_sig_bouncy = sig;
  assign bus.o_done       = done;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: driver predicts each burst from an
// LFSR sequence model, a negedge monitor pops and compares.
module tb_switch_bounce_gen;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_accept = 0;

`ifdef SBG_FORCE_FIRST_EDGE_EN
  localparam bit FORCE_FIRST = 1'b1;
`else
  localparam bit FORCE_FIRST = 1'b0;
`endif

  switch_bounce_gen_if #(.BOUNCE_W(8)) bus  ();
  switch_bounce_gen_if #(.BOUNCE_W(8)) bus2 ();

  switch_bounce_gen #(.BOUNCE_W(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  switch_bounce_gen #(.BOUNCE_W(8), .LFSR_SEED(16'h0000)) dut2 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus2)
  );

  typedef struct {
    logic sig;
    logic done;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_lfsr;
  logic [15:0] m_lfsr2;
  logic        cur_level;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR sequences: one step per non-reset edge, seed on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rstn) begin
      m_lfsr  <= 16'hACE1;
      m_lfsr2 <= 16'h0001;
    end else begin
      m_lfsr  <= lstep(m_lfsr);
      m_lfsr2 <= lstep(m_lfsr2);
    end
  end

  always @(negedge clk) begin
    if (rstn && (bus.o_busy || bus.o_done)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_busy_done", {30'd0, bus.o_busy, bus.o_done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sig_bouncy", bus.o_sig_bouncy, e.sig);
        check("done",       bus.o_done,       e.done);
        check("busy",       bus.o_busy,       !e.done);
      end
    end
  end

  task automatic send(input logic lvl, input int len, input bit hold);
    int          guard;
    exp_t        e;
    logic        s;
    logic [15:0] lf;
    guard = 0;
    @(negedge clk);
    while (!bus.o_ready && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.o_ready) check("ready_timeout", bus.o_ready, 1);
    bus.i_valid      = 1'b1;
    bus.i_level      = lvl;
    bus.i_bounce_len = 8'(len);
    @(posedge clk);
    #1;
    last_accept = cyc;
    lf = m_lfsr;
    s  = cur_level;
    e.sig = s; e.done = 1'b0; sb_q.push_back(e);
    for (int k = 1; k <= len; k++) begin
      if (FORCE_FIRST && k == 1) s = lvl;
      else                       s = s ^ lf[0];
      lf = lstep(lf);
      e.sig = s; e.done = 1'b0; sb_q.push_back(e);
    end
    e.sig = lvl; e.done = 1'b1; sb_q.push_back(e);
    cur_level = lvl;
    if (hold) begin
      bus.i_level      = 1'($urandom);
      bus.i_bounce_len = 8'($urandom);
    end else begin
      bus.i_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] lf;
    logic        s;
    int          t1;
    int          guard;

    bus.i_valid = 1'b0;  bus.i_level = 1'b0;  bus.i_bounce_len = '0;
    bus2.i_valid = 1'b0; bus2.i_level = 1'b0; bus2.i_bounce_len = '0;
    cur_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.o_ready, 1);
    check("rst_sig",   bus.o_sig_bouncy, 0);
    check("rst_busy",  bus.o_busy, 0);
    check("rst_done",  bus.o_done, 0);
    #1 rstn = 1'b1;

    // Zero seed on dut2: sequence from 1, burst of 255 then settle at edge 256.
    @(negedge clk);
    bus2.i_valid = 1'b1; bus2.i_level = 1'b1; bus2.i_bounce_len = 8'd255;
    @(posedge clk);
    #1;
    bus2.i_valid = 1'b0;
    lf = m_lfsr2;
    s  = 1'b0;
    check("seed0_busy_start", bus2.o_busy, 1);
    for (int k = 1; k <= 255; k++) begin
      @(posedge clk);
      #1;
      if (FORCE_FIRST && k == 1) s = 1'b1;
      else                       s = s ^ lf[0];
      lf = lstep(lf);
      check("seed0_sig",  bus2.o_sig_bouncy, s);
      check("seed0_done", bus2.o_done, 0);
    end
    @(posedge clk);
    #1;
    check("seed0_final_sig",  bus2.o_sig_bouncy, 1);
    check("seed0_final_done", bus2.o_done, 1);
    check("seed0_ready",      bus2.o_ready, 1);

    // Clean edge.
    send(1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    check("clean_ready", bus.o_ready, 1);
    check("clean_sig",   bus.o_sig_bouncy, 1);

    // Burst of 20 with valid held (junk) during it, then back-to-back (0,3).
    send(1'b1, 20, 1'b1);
    t1 = last_accept;
    send(1'b0, 3, 1'b0);
    check("b2b_accept_gap", last_accept - t1, 22);

    // Rising command from level 0 with L=8.
    send(1'b0, 0, 1'b0);
    send(1'b1, 8, 1'b0);

    // Reset in the middle of an L=50 burst.
    send(1'b1, 50, 1'b0);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    @(posedge clk);
    #1;
    sb_q.delete();
    cur_level = 1'b0;
    check("midrst_sig",   bus.o_sig_bouncy, 0);
    check("midrst_ready", bus.o_ready, 1);
    check("midrst_done",  bus.o_done, 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (3) @(posedge clk);
    send(1'b1, 20, 1'b0);

    for (int i = 0; i < 40; i++) begin
      bit hold;
      hold = ($urandom_range(0, 3) == 0) && (i < 39);
      send(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    bus.i_valid = 1'b0;

    guard = 0;
    while (sb_q.size() != 0 && guard < 300) begin
      @(posedge clk);
      guard++;
    end
    repeat (2) @(posedge clk);
    check("sb_drain", sb_q.size(), 0);
    check("end_ready", bus.o_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
